csa_accum_ctrl: RTL and testbench

//  Sequential multi-operand accumulator built around one 18-bit carry-save stage.

---
 rtl/csa_acc_pkg.sv | 14 +
 rtl/csa_accum_ctrl_csa18.sv | 17 +
 rtl/csa_accum_ctrl.sv | 136 +++++++++++++
 tb/tb_csa_accum_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and default sizing for the carry-save accumulator controller.
// Optional feature macro used by this slice: CSA_ACC_OVF_EN.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ACC,
        CPA,
        OUT
    } state_t;

    localparam int unsigned W_DEF       = 18;
    localparam int unsigned MAX_OPS_DEF = 16;

endpackage

// File: rtl/csa_accum_ctrl_csa18.sv
// 18-bit carry-save stage: three operands in, redundant sum/carry out.
// Bit i of c_out carries weight 2^(i+1); the caller does the shift.
module CSA18 (
    input  logic [17:0] a,
    input  logic [17:0] b,
    input  logic [17:0] c_in,
    output logic [17:0] s,
    output logic [17:0] c_out
);

    // Bitwise full adders, no carry propagation between bit positions
    always_comb begin
        s     = a ^ b ^ c_in;
        c_out = (a & b) | (a & c_in) | (b & c_in);
    end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Sequential multi-operand accumulator around one carry-save stage.
// Operands fold into a redundant sum/carry pair; one carry-propagate add
// finalises the sequence. Define CSA_ACC_OVF_EN to add the sticky out_ovf flag.
module csa_accum_ctrl
    import csa_acc_pkg::*;
#(
    parameter  int unsigned W       = W_DEF,
    parameter  int unsigned MAX_OPS = MAX_OPS_DEF,
    localparam int unsigned CW      = $clog2(MAX_OPS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count
`ifdef CSA_ACC_OVF_EN
    ,
    output logic          out_ovf
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  s_reg;
    logic [W-1:0]  c_reg;
    logic [CW-1:0] count;
    logic [W-1:0]  c_shift;
    logic [W-1:0]  csa_s;
    logic [W-1:0]  csa_c;
    logic          last_op;
`ifdef CSA_ACC_OVF_EN
    logic          ovf_reg;
    logic [W:0]    cpa_full;
    logic          ovf_fin;
`else
    logic [W-1:0]  cpa_sum;
`endif

    // The top carry bit falls off here; it only matters to the overflow flag
    assign c_shift = {c_reg[W-2:0], 1'b0};

    CSA18 u_csa (
        .a     (s_reg),
        .b     (c_shift),
        .c_in  (in_data),
        .s     (csa_s),
        .c_out (csa_c)
    );

    // Carry-propagate add and finalisation condition
    always_comb begin
        last_op = in_last || (count == CW'(MAX_OPS - 1));
`ifdef CSA_ACC_OVF_EN
        cpa_full = {1'b0, s_reg} + {1'b0, c_shift};
        ovf_fin  = ovf_reg | c_reg[W-1] | cpa_full[W];
`else
        cpa_sum  = s_reg + c_shift;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (in_valid && last_op) state_nxt = CPA;
            CPA:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == OUT);
    end

    // Datapath: fold operands in ACC, resolve and clear in CPA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg     <= '0;
            c_reg     <= '0;
            count     <= '0;
            out_data  <= '0;
            out_count <= '0;
`ifdef CSA_ACC_OVF_EN
            ovf_reg   <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        s_reg <= csa_s;
                        c_reg <= csa_c;
                        count <= count + 1'b1;
`ifdef CSA_ACC_OVF_EN
                        if (c_reg[W-1]) ovf_reg <= 1'b1;
`endif
                    end
                end
                CPA: begin
`ifdef CSA_ACC_OVF_EN
                    out_data <= cpa_full[W-1:0];
                    ovf_reg  <= ovf_fin;
                    out_ovf  <= ovf_fin;
`else
                    out_data <= cpa_sum;
`endif
                    out_count <= count;
                    s_reg     <= '0;
                    c_reg     <= '0;
                    count     <= '0;
                end
                OUT: begin
`ifdef CSA_ACC_OVF_EN
                    if (out_ready) ovf_reg <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: default instance plus a MAX_OPS=4
// instance for auto-finalisation. Overflow checks follow CSA_ACC_OVF_EN.
module tb_csa_accum_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [17:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [17:0] out_data;
    logic [4:0]  out_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [17:0] out_data4;
    logic [2:0]  out_count4;

`ifdef CSA_ACC_OVF_EN
    logic        out_ovf;
    logic        out_ovf4;
`endif

    int n_total;
    int n_bad;

    csa_accum_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef CSA_ACC_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    csa_accum_ctrl #(.MAX_OPS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_data  (out_data4),
        .out_count (out_count4)
`ifdef CSA_ACC_OVF_EN
        ,
        .out_ovf   (out_ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("consume_valid", 32'(out_valid), 32'd0);
        check("consume_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
`ifdef CSA_ACC_OVF_EN
        check("rst_ovf", 32'(out_ovf), 32'd0);
`endif
        step();

        // MAX_OPS=4 instance finalises on its own after four operands
        send(18'd5, 1'b0);
        send(18'd5, 1'b0);
        send(18'd5, 1'b0);
        check("max_ready_3", 32'(in_ready4), 32'd1);
        send(18'd5, 1'b0);
        check("max_cpa_valid", 32'(out_valid4), 32'd0);
        check("max_cpa_ready", 32'(in_ready4), 32'd0);
        step();
        check("max_valid", 32'(out_valid4), 32'd1);
        check("max_data", 32'(out_data4), 32'd20);
        check("max_count", 32'(out_count4), 32'd4);
        pulse_reset();
        check("max_rst_valid", 32'(out_valid4), 32'd0);

        // 1 + 2 + 3
        send(18'd1, 1'b0);
        send(18'd2, 1'b0);
        send(18'd3, 1'b1);
        check("t1_cpa_valid", 32'(out_valid), 32'd0);
        check("t1_cpa_ready", 32'(in_ready), 32'd0);
        step();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'd6);
        check("t1_count", 32'(out_count), 32'd3);
`ifdef CSA_ACC_OVF_EN
        check("t1_ovf", 32'(out_ovf), 32'd0);
`endif
        consume();

        // Wrap-around: 3FFFF + 1
        send(18'h3FFFF, 1'b0);
        send(18'h00001, 1'b1);
        step();
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data", 32'(out_data), 32'd0);
        check("t2_count", 32'(out_count), 32'd2);
`ifdef CSA_ACC_OVF_EN
        check("t2_ovf", 32'(out_ovf), 32'd1);
`endif
        consume();

        // Back-pressure: result holds, operands refused while stalled
        send(18'd4, 1'b0);
        send(18'd4, 1'b1);
        step();
        in_valid = 1'b1;
        in_data  = 18'd123;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_data", 32'(out_data), 32'd8);
            check("t4_hold_ready", 32'(in_ready), 32'd0);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        consume();
        send(18'd9, 1'b1);
        step();
        check("t4_next_data", 32'(out_data), 32'd9);
        check("t4_next_count", 32'(out_count), 32'd1);
        consume();

        // Reset mid-sequence discards partial state
        send(18'd7, 1'b0);
        send(18'd7, 1'b0);
        pulse_reset();
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_data", 32'(out_data), 32'd0);
        check("t5_count", 32'(out_count), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        step();
        send(18'd7, 1'b1);
        step();
        check("t5_new_data", 32'(out_data), 32'd7);
        check("t5_new_count", 32'(out_count), 32'd1);
        consume();

        // Single operand passes through unchanged
        send(18'h2AAAA, 1'b1);
        step();
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_data", 32'(out_data), 32'h2AAAA);
        check("t6_count", 32'(out_count), 32'd1);
`ifdef CSA_ACC_OVF_EN
        check("t6_ovf", 32'(out_ovf), 32'd0);
`endif
        consume();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
